// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing the aFifo write port
// among NUM_REQ requesters in the FIFO write-clock domain.
module afifo_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_BURST       = 16,
  parameter int BURST_CNT_WIDTH = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n_in,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  input  logic [NUM_REQ-1:0]            Last_in,
  output logic [NUM_REQ-1:0]            Ack_out,
  output logic [NUM_REQ-1:0]            Grant_out,
  input  logic                          Full_in,
  output logic                          WriteEn_out,
  output logic [DATA_WIDTH-1:0]         FifoData_out,
  output logic                          Busy_out
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_e;

  state_e                     state_q, state_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic                       busy_q, busy_d;
  logic [BURST_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]              ptr_q, ptr_d;

  logic [PW-1:0]         own_idx;
  logic [PW-1:0]         pick_idx;
  logic                  pick_vld;
  logic                  req_g;
  logic                  last_g;
  logic                  xfer;
  logic                  cap_hit;
  logic [DATA_WIDTH-1:0] fdata;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] p,
    input int            k
  );
    return PW'((int'(p) + k) % NUM_REQ);
  endfunction

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) own_idx = PW'(i);
  end

  // Scan farthest-first so the nearest set index after ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (Req_in[rr_idx(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    fdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      fdata = fdata |
        (Data_in[i*DATA_WIDTH +: DATA_WIDTH] &
         {DATA_WIDTH{grant_q[i]}});
  end

  assign req_g   = |(Req_in & grant_q);
  assign last_g  = |(Last_in & grant_q);
  assign xfer    = (state_q == XFER) & req_g & ~Full_in;
  assign cap_hit = (cnt_q == BURST_CNT_WIDTH'(MAX_BURST - 1));

  assign WriteEn_out  = xfer;
  assign Ack_out      = grant_q & {NUM_REQ{xfer}};
  assign FifoData_out = fdata;
  assign Grant_out    = grant_q;
  assign Busy_out     = busy_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = XFER;
          grant_d = NUM_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      XFER: begin
        // Abandon releases without a write; no req_g means no xfer.
        if (!req_g || (xfer && (last_g || cap_hit))) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = own_idx;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: per-cycle vector table plus a word
// scoreboard checking FIFO data order per requester.
module tb_afifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          Clk;
  logic          Reset_n_in;
  logic [N-1:0]  Req_in;
  logic [N*DW-1:0] Data_in;
  logic [N-1:0]  Last_in;
  logic [N-1:0]  Ack_out;
  logic [N-1:0]  Grant_out;
  logic          Full_in;
  logic          WriteEn_out;
  logic [DW-1:0] FifoData_out;
  logic          Busy_out;

  afifo_wr_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .MAX_BURST(4),
    .BURST_CNT_WIDTH(8)
  ) dut (
    .Clk(Clk),
    .Reset_n_in(Reset_n_in),
    .Req_in(Req_in),
    .Data_in(Data_in),
    .Last_in(Last_in),
    .Ack_out(Ack_out),
    .Grant_out(Grant_out),
    .Full_in(Full_in),
    .WriteEn_out(WriteEn_out),
    .FifoData_out(FifoData_out),
    .Busy_out(Busy_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         cnt[N];
  int         expcnt[N];
  logic [3:0] ack_seen;
  int         passed;
  int         total;
  int         cur_row;
  int         seg[8];

  function automatic logic [7:0] mkdata(input int i, input int c);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(i + 1);
    lo = 4'(c);
    return {hi, lo};
  endfunction

  function automatic void a(
    input logic [3:0] req, input logic [3:0] last,
    input logic full, input logic [3:0] grant,
    input logic [3:0] ack, input logic busy
  );
    vec_t v;
    v.req = req; v.last = last; v.full = full;
    v.grant = grant; v.ack = ack; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %0h expected %0h",
                  nm, cur_row, act, exp);
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++)
      Data_in[i*DW +: DW] = mkdata(i, cnt[i]);
  endtask

  task automatic run_rows(input int s, input int e);
    vec_t v;
    int o;
    for (int r = s; r < e; r++) begin
      cur_row = r;
      v = vecs[r];
      @(posedge Clk); #1;
      for (int i = 0; i < N; i++) if (ack_seen[i]) cnt[i]++;
      drive_data();
      Req_in  = v.req;
      Last_in = v.last;
      Full_in = v.full;
      if (v.ack != 0) begin
        o = 0;
        for (int i = 0; i < N; i++) if (v.ack[i]) o = i;
        sb_q.push_back(mkdata(o, expcnt[o]));
        expcnt[o]++;
      end
      @(negedge Clk);
      chk("grant", 32'(Grant_out), 32'(v.grant));
      chk("ack", 32'(Ack_out), 32'(v.ack));
      chk("wen", 32'(WriteEn_out), 32'(v.ack != 0));
      chk("busy", 32'(Busy_out), 32'(v.busy));
      if (v.grant == 0) chk("fdata_idle", 32'(FifoData_out), 0);
      if (WriteEn_out) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL sb_extra row %0d: got write %0h expected none",
                   r, FifoData_out);
        end else begin
          chk("fdata", 32'(FifoData_out), 32'(sb_q.pop_front()));
        end
      end
      ack_seen = Ack_out;
    end
  endtask

  task automatic do_reset();
    Reset_n_in = 1'b0;
    Req_in  = '0;
    Last_in = '0;
    Full_in = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_grant", 32'(Grant_out), 0);
    chk("rst_busy", 32'(Busy_out), 0);
    chk("rst_wen", 32'(WriteEn_out), 0);
    chk("rst_ack", 32'(Ack_out), 0);
    chk("rst_fdata", 32'(FifoData_out), 0);
    Reset_n_in = 1'b1;
    ack_seen = '0;
    for (int i = 0; i < N; i++) expcnt[i] = cnt[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    passed = 0; total = 0; cur_row = -1;
    ack_seen = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; expcnt[i] = 0; end
    Reset_n_in = 1'b1;
    Req_in = '0; Last_in = '0; Full_in = 1'b0; Data_in = '0;

    // single requester, 3-word packet
    seg[0] = vecs.size();
    a(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    a(4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    a(4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // all requesting, single-word packets
    seg[1] = vecs.size();
    a(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    a(4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1);
    a(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    a(4'b1111, 4'b1111, 0, 4'b0010, 4'b0010, 1);
    a(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    a(4'b1111, 4'b1111, 0, 4'b0100, 4'b0100, 1);
    a(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    a(4'b1111, 4'b1111, 0, 4'b1000, 4'b1000, 1);
    a(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    a(4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // burst cap: req 2 sends 10 words, req 3 interleaves
    seg[2] = vecs.size();
    a(4'b1100, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 4; k++)
      a(4'b1100, 4'b0000, 0, 4'b0100, 4'b0100, 1);
    a(4'b1100, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b1100, 4'b1000, 0, 4'b1000, 4'b1000, 1);
    a(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 4; k++)
      a(4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1);
    a(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1);
    a(4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // Full for 5 cycles mid-packet; Last while full is ignored
    seg[3] = vecs.size();
    a(4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1);
    for (int k = 0; k < 5; k++)
      a(4'b0010, 4'b0010, 1, 4'b0010, 4'b0000, 1);
    a(4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1);
    a(4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // requester 0 abandons, requester 1 pending
    seg[4] = vecs.size();
    a(4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0011, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    a(4'b0011, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    a(4'b0010, 4'b0000, 0, 4'b0001, 4'b0000, 1);
    a(4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // burst in progress, interrupted by async reset
    seg[5] = vecs.size();
    a(4'b0110, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    a(4'b0110, 4'b0000, 0, 4'b0100, 4'b0100, 1);
    // after reset requester 0 must win first
    seg[6] = vecs.size();
    a(4'b0111, 4'b0111, 0, 4'b0000, 4'b0000, 0);
    a(4'b0111, 4'b0111, 0, 4'b0001, 4'b0001, 1);
    a(4'b0111, 4'b0111, 0, 4'b0000, 4'b0000, 0);
    a(4'b0111, 4'b0111, 0, 4'b0010, 4'b0010, 1);
    a(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    seg[7] = vecs.size();

    #3;
    do_reset();
    run_rows(seg[0], seg[1]);
    do_reset();
    for (int s = 1; s < 6; s++) run_rows(seg[s], seg[s+1]);

    // async reset between edges: outputs drop with no clock edge
    #2;
    Reset_n_in = 1'b0;
    #1;
    cur_row = -2;
    chk("async_grant", 32'(Grant_out), 0);
    chk("async_busy", 32'(Busy_out), 0);
    chk("async_wen", 32'(WriteEn_out), 0);
    chk("async_ack", 32'(Ack_out), 0);
    do_reset();
    run_rows(seg[6], seg[7]);

    cur_row = -3;
    chk("sb_leftover", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Shares the single write port of the dual-clock FIFO (aFifo) among NUM_REQ requesters in the FIFO write-clock domain.
- Round-robin arbitration at packet granularity. A grant is held until the packet's last word, a MAX_BURST cap, or the requester dropping its request.
- Drives WriteEn/Data of the FIFO directly and obeys Full so the FIFO never sees a write while full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width; must equal aFifo DATA_WIDTH.
- MAX_BURST, 16, maximum words per grant before forced re-arbitration (1..256).
- BURST_CNT_WIDTH, 8, burst counter width; must satisfy 2^BURST_CNT_WIDTH >= MAX_BURST.

Ports:
- Clk  input  1  FIFO write clock (WClk of aFifo).
- Reset_n_in  input  1  asynchronous active-low reset.
- Req_in  input  NUM_REQ  per-requester word-valid; held high while the requester has data.
- Data_in  input  NUM_REQ*DATA_WIDTH  requester i word on bits [i*DATA_WIDTH +: DATA_WIDTH].
- Last_in  input  NUM_REQ  marks the final word of requester i's packet; qualified by Req_in[i].
- Ack_out  output  NUM_REQ  one-hot; word of requester i accepted this cycle; requester advances on Clk edge.
- Grant_out  output  NUM_REQ  registered one-hot current owner; all-zero when idle.
- Full_in  input  1  aFifo Full_out.
- WriteEn_out  output  1  to aFifo WriteEn_in.
- FifoData_out  output  DATA_WIDTH  to aFifo Data_in.
- Busy_out  output  1  registered; 1 while in XFER.

Behaviour:
- Reset (Reset_n_in low, asynchronous): state=IDLE, Grant_out=0, Busy_out=0, burst count=0, RR pointer=NUM_REQ-1 so requester 0 wins first. Combinational outputs are then WriteEn_out=0, Ack_out=0, FifoData_out=0. Deassertion is synchronised externally.
- FSM, two states:
  - IDLE: if any Req_in bit is set, choose the first set index searching pointer+1, pointer+2, ... modulo NUM_REQ. Register its one-hot in Grant_out, set Busy_out, clear the burst count, go to XFER. No write occurs in IDLE.
  - XFER, owner g:
    - xfer = Req_in[g] & ~Full_in.
    - WriteEn_out = xfer; Ack_out[g] = xfer; other Ack bits 0.
    - FifoData_out = Data_in slice g, combinational mux; 0 when Grant_out=0.
  - XFER release conditions, taking effect on the next edge: go to IDLE, Grant_out=0, Busy_out=0, pointer=g.
    - (a) xfer & Last_in[g];
    - (b) xfer & burst count == MAX_BURST-1;
    - (c) ~Req_in[g], i.e. abandon; takes priority and no write occurs.
  - Otherwise, in XFER: burst count increments on each xfer; stay in XFER.
- Latency:
  - Request to first write: 1 cycle, i.e. grant registered in IDLE, write in the first XFER cycle.
  - Every release costs exactly one IDLE cycle before the next grant.
  - Sustained throughput is MAX_BURST/(MAX_BURST+1) words/cycle when not full.
- Full_in high in XFER: no write, no Ack, no count change; grant is held indefinitely while Req_in[g] stays high.
- Full_in is asynchronously preset in aFifo. It is treated as a level sampled combinationally; it may rise mid-burst and the stall is immediate.
- Requests arriving mid-burst from other requesters wait; no preemption.
- Simultaneous release and new requests: the new grant is evaluated in the following IDLE cycle with the updated pointer.
- MAX_BURST=1: every word releases; this gives strict per-word round-robin.
- Wrap-around: pointer NUM_REQ-1 searches from index 0; the burst counter never exceeds MAX_BURST-1.
- Last_in and Data_in of non-owners are ignored. Last_in[g] on a non-accepted (Full) cycle has no effect.
- Reset mid-burst: the grant is dropped immediately. The packet is truncated in the FIFO; the upstream block handles it.

Test Plan:
- Reset, then Req_in=4'b0001, 3-word packet (Last on word 3), Full_in=0 → Grant_out=0001 one cycle after Req; WriteEn_out high 3 consecutive cycles with data A0,A1,A2; then Grant_out=0000, Busy_out=0.
- Req_in=4'b1111 all continuous, single-word packets → grants in order 0,1,2,3,0 with one IDLE cycle between them; 4 writes in 8 cycles.
- MAX_BURST=4, requester 2 sends a 10-word packet with no Last, requester 3 also requesting → requester 2 writes 4 words, requester 3 is served next, then requester 2 resumes.
- Full_in=1 for 5 cycles mid-packet of requester 1 → WriteEn_out=0 and Ack_out=0 for those 5 cycles; grant held; remaining words written after Full drops with no duplicates or loss.
- Requester 0 drops Req_in after 2 of 5 words, requester 1 pending → release without a write in the drop cycle; Grant_out=0010 two cycles later.
- Assert Reset_n_in low mid-burst between clock edges → Grant_out, Busy_out, WriteEn_out go 0 without a clock edge; after release requester 0 wins first.
